// File: rtl/inv_key_schedule.sv
// AES-128 key expansion with a round-key store, read back in decryption order.
// One round key is produced per clock through a single shared SubWord/Rcon datapath.
module inv_key_schedule #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [KW-1:0] key_in,
    input  logic          rewind,
    input  logic          key_req,
    output logic          busy,
    output logic          key_ready,
    output logic [KW-1:0] rk_out,
    output logic [3:0]    rk_round,
    output logic          rk_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_t        state_reg, state_next;
    logic [KW-1:0] cur_reg;
    logic [3:0]    cnt_reg;
    logic [3:0]    rd_ptr_reg;
    logic          busy_reg, key_ready_reg, rk_valid_reg;
    logic [KW-1:0] rk_out_reg;
    logic [3:0]    rk_round_reg;

    logic [KW-1:0] key_store [0:NR];

    logic          start, step, fire, do_rewind;
    logic [31:0]   rot_word, sub_word, temp_word;
    logic [31:0]   w0_next, w1_next, w2_next, w3_next;
    logic [KW-1:0] nxt_key;
    logic [7:0]    rcon;

    always_comb begin
        rcon = 8'h00;
        case (cnt_reg)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign rot_word = {cur_reg[23:0], cur_reg[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            assign sub_word[gi*8 +: 8] = SBOX[rot_word[gi*8 +: 8]];
        end
    endgenerate

    assign temp_word = sub_word ^ {rcon, 24'h000000};
    assign w0_next   = cur_reg[127:96] ^ temp_word;
    assign w1_next   = cur_reg[95:64]  ^ w0_next;
    assign w2_next   = cur_reg[63:32]  ^ w1_next;
    assign w3_next   = cur_reg[31:0]   ^ w2_next;
    assign nxt_key   = {w0_next, w1_next, w2_next, w3_next};

    // Next state plus one-hot action strobes; READY honours load > rewind > key_req.
    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        step       = 1'b0;
        fire       = 1'b0;
        do_rewind  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    start      = 1'b1;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (cnt_reg == LAST_ROUND)
                    state_next = READY;
            end
            READY: begin
                if (load) begin
                    start      = 1'b1;
                    state_next = EXPAND;
                end else if (rewind) begin
                    do_rewind = 1'b1;
                end else if (key_req) begin
                    fire = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Key store: write port during expansion only, contents need no reset.
    always_ff @(posedge clk) begin
        if (start)
            key_store[0] <= key_in;
        else if (step)
            key_store[cnt_reg] <= nxt_key;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cur_reg       <= '0;
            cnt_reg       <= 4'd0;
            rd_ptr_reg    <= LAST_ROUND;
            busy_reg      <= 1'b0;
            key_ready_reg <= 1'b0;
            rk_valid_reg  <= 1'b0;
            rk_out_reg    <= '0;
            rk_round_reg  <= 4'd0;
        end else begin
            state_reg    <= state_next;
            rk_valid_reg <= fire;
            if (start) begin
                cur_reg       <= key_in;
                cnt_reg       <= 4'd1;
                busy_reg      <= 1'b1;
                key_ready_reg <= 1'b0;
            end else if (step) begin
                cur_reg <= nxt_key;
                cnt_reg <= cnt_reg + 4'd1;
                if (cnt_reg == LAST_ROUND) begin
                    busy_reg      <= 1'b0;
                    key_ready_reg <= 1'b1;
                    rd_ptr_reg    <= LAST_ROUND;
                end
            end
            if (do_rewind)
                rd_ptr_reg <= LAST_ROUND;
            // Wrap 0 -> NR so back-to-back blocks reuse the same schedule.
            if (fire) begin
                rk_out_reg   <= key_store[rd_ptr_reg];
                rk_round_reg <= rd_ptr_reg;
                rd_ptr_reg   <= (rd_ptr_reg == 4'd0) ? LAST_ROUND : rd_ptr_reg - 4'd1;
            end
        end
    end

    assign busy      = busy_reg;
    assign key_ready = key_ready_reg;
    assign rk_valid  = rk_valid_reg;
    assign rk_out    = rk_out_reg;
    assign rk_round  = rk_round_reg;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule using FIPS-197 key expansion vectors.
module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst, load, rewind, key_req;
    logic [127:0] key_in;
    logic         busy, key_ready, rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_X  = 128'hffeeddccbbaa99887766554433221100;

    logic [127:0] a1_rk [0:10];

    inv_key_schedule #(.NR(10), .KW(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .key_in    (key_in),
        .rewind    (rewind),
        .key_req   (key_req),
        .busy      (busy),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        a1_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        a1_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset with load/key_req held high
        rst = 1'b1; load = 1'b1; key_req = 1'b1; rewind = 1'b0; key_in = KEY_A1;
        tick(2);
        check("rst_busy",      128'(busy),      128'(0));
        check("rst_key_ready", 128'(key_ready), 128'(0));
        check("rst_rk_valid",  128'(rk_valid),  128'(0));
        check("rst_rk_out",    rk_out,          128'(0));
        check("rst_rk_round",  128'(rk_round),  128'(0));
        rst = 1'b0; load = 1'b0; key_req = 1'b0;

        // A.1 load, with a stray load mid-expansion that must be ignored
        load = 1'b1; key_in = KEY_A1;
        tick(1);
        load = 1'b0;
        check("a1_busy_e0", 128'(busy), 128'(1));
        tick(3);
        load = 1'b1; key_in = KEY_X;
        tick(1);
        load = 1'b0; key_in = KEY_A1;
        tick(4);
        check("a1_not_ready_e9", 128'(key_ready), 128'(0));
        tick(1);
        check("a1_busy_e10", 128'(busy), 128'(1));
        tick(1);
        check("a1_ready_e11", 128'(key_ready), 128'(1));
        check("a1_idle_e11",  128'(busy),      128'(0));
        check("a1_novalid",   128'(rk_valid),  128'(0));

        // Continuous requests: 10..0 then wrap to 10
        key_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int r;
            r = (i <= 10) ? 10 - i : 10;
            tick(1);
            check($sformatf("a1_seq%0d_valid", i), 128'(rk_valid), 128'(1));
            check($sformatf("a1_seq%0d_round", i), 128'(rk_round), 128'(r));
            check($sformatf("a1_seq%0d_key", i),   rk_out,         a1_rk[r]);
        end
        key_req = 1'b0;
        tick(1);
        check("a1_hold_valid", 128'(rk_valid), 128'(0));
        check("a1_hold_round", 128'(rk_round), 128'(10));
        check("a1_hold_key",   rk_out,         a1_rk[10]);

        // Rewind wins over key_req
        rewind = 1'b1; key_req = 1'b1;
        tick(1);
        rewind = 1'b0;
        check("a1_rewind_novalid", 128'(rk_valid), 128'(0));
        tick(1);
        key_req = 1'b0;
        check("a1_rewind_round", 128'(rk_round), 128'(10));
        check("a1_rewind_key",   rk_out,         a1_rk[10]);

        // C.1 key from READY
        load = 1'b1; key_in = KEY_C1;
        tick(1);
        load = 1'b0;
        check("c1_busy",     128'(busy),      128'(1));
        check("c1_notready", 128'(key_ready), 128'(0));
        tick(10);
        check("c1_ready", 128'(key_ready), 128'(1));
        key_req = 1'b1;
        tick(1);
        check("c1_r10_round", 128'(rk_round), 128'(10));
        check("c1_r10_key",   rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        tick(1);
        check("c1_r9_round", 128'(rk_round), 128'(9));
        check("c1_r9_key",   rk_out, 128'h549932d1f08557681093ed9cbe2c974e);
        tick(1);
        check("c1_r8_round", 128'(rk_round), 128'(8));
        key_req = 1'b0; rewind = 1'b1;
        tick(1);
        rewind = 1'b0;
        check("c1_rewind_novalid", 128'(rk_valid), 128'(0));
        key_req = 1'b1;
        tick(1);
        key_req = 1'b0;
        check("c1_after_rewind_valid", 128'(rk_valid), 128'(1));
        check("c1_after_rewind_round", 128'(rk_round), 128'(10));
        check("c1_after_rewind_key",   rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // load + key_req together in READY: load wins
        load = 1'b1; key_req = 1'b1; key_in = KEY_A1;
        tick(1);
        load = 1'b0; key_req = 1'b0;
        check("ldreq_novalid", 128'(rk_valid),  128'(0));
        check("ldreq_busy",    128'(busy),      128'(1));
        check("ldreq_notready", 128'(key_ready), 128'(0));

        // Abort at cnt=5 with reset
        tick(4);
        check("abort_busy_before", 128'(busy), 128'(1));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("abort_busy",      128'(busy),      128'(0));
        check("abort_key_ready", 128'(key_ready), 128'(0));
        check("abort_rk_out",    rk_out,          128'(0));
        check("abort_rk_round",  128'(rk_round),  128'(0));
        key_req = 1'b1;
        tick(12);
        key_req = 1'b0;
        check("abort_stays_idle", 128'(key_ready), 128'(0));
        check("abort_no_valid",   128'(rk_valid),  128'(0));

        // Fresh load after abort
        load = 1'b1; key_in = KEY_C1;
        tick(1);
        load = 1'b0;
        tick(10);
        check("fresh_ready", 128'(key_ready), 128'(1));
        key_req = 1'b1;
        tick(1);
        key_req = 1'b0;
        check("fresh_r10_round", 128'(rk_round), 128'(10));
        check("fresh_r10_key",   rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        tick(1);
        check("fresh_valid_drop", 128'(rk_valid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
Upstream neighbour of doInvRound: expands one AES-128 cipher key into all 11 round keys and stores them. It then serves the keys in decryption order (round 10 down to round 0), one per request, onto the key_in bus of the inverse-round datapath. The expansion is sequential, one round key per clock, so a single SubWord/Rcon datapath is shared across all rounds.

Parameters:
NR, 10, number of AES rounds (AES-128 only; other values unsupported)
KW, 128, key / round-key width in bits

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
load  input  1  single-cycle strobe: capture key_in and start expansion
key_in  input  128  cipher key, byte 0 in [127:120] (same ordering as data_in of the round stage)
rewind  input  1  reset read pointer to round NR without producing output
key_req  input  1  request next round key (decryption order)
busy  output  1  high while expansion is in progress
key_ready  output  1  all 11 round keys stored; requests accepted
rk_out  output  128  round key delivered
rk_round  output  4  round index of rk_out (10..0)
rk_valid  output  1  one-cycle pulse: rk_out/rk_round valid

Behaviour:
- State machine IDLE -> EXPAND -> READY. All outputs are registered.
- Reset (rst=1 at a clock edge, regardless of state): state=IDLE; busy=0, key_ready=0, rk_valid=0, rk_out=0, rk_round=0, cnt=0, rd_ptr=NR. Key store contents are don't-care. Reset mid-expansion aborts the expansion.
- IDLE: load=1 -> store[0]=key_in, cur=key_in, cnt=1, state=EXPAND, busy=1. key_req and rewind are ignored.
- EXPAND: each edge computes nxt=f(cur,Rcon[cnt]), writes store[cnt]=nxt, sets cur=nxt, and increments cnt.
  - f is the FIPS-197 schedule: t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - w0 is bits [127:96].
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - SubWord uses an internal 256-entry forward S-box (4 lookups, combinational).
  - On the edge that writes cnt=NR: state=READY, busy=0, key_ready=1, rd_ptr=NR.
  - load, key_req and rewind are ignored during EXPAND.
- Latency: load sampled at edge E0 gives key_ready=1 after edge E0+10, i.e. 11 edges total. busy is high from after E0 through edge E0+10.
- READY, priority order load > rewind > key_req:
  - load: restart expansion as in IDLE; key_ready=0 next cycle; no rk_valid.
  - rewind: rd_ptr=NR; no rk_valid that cycle.
  - key_req:
    - Next edge: rk_out=store[rd_ptr], rk_round=rd_ptr, rk_valid=1.
    - rd_ptr decrements. After delivering round 0, rd_ptr wraps to NR so the next block reuses the same key.
  - No request: rk_valid=0; rk_out and rk_round hold their last values.
- key_req may stay high continuously: one key per cycle, back to back, with the wrap from 0 to 10 seamless.
- rk_valid is never asserted outside READY.

Test Plan:
- Reset: assert rst for 2 cycles with load=1 and key_req=1 -> busy=0, key_ready=0, rk_valid=0, rk_out=0, rk_round=0.
- FIPS-197 A.1: load key 2b7e151628aed2a6abf7158809cf4f3c.
  - key_ready rises exactly 11 edges after load.
  - First key_req -> rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Continuous key_req for 12 cycles after the A.1 load:
  - rk_round sequence 10,9,...,1,0,10.
  - Round 1 key = a0fafe1788542cb123a339392a6c7605.
  - Round 0 key = the cipher key.
- Load key 000102030405060708090a0b0c0d0e0f -> round 10 key = 13111d7fe3944a17f307a78b4d2b30c5.
  - Then key_req 3 times, then rewind, then key_req -> rk_round=10 again.
- Protocol edges:
  - key_req and load in the same READY cycle -> no rk_valid; busy=1 next cycle.
  - load during EXPAND -> ignored, keys unchanged.
  - rst asserted at cnt=5 -> IDLE.
  - A fresh load afterwards gives correct keys.
- Integration: the round-10 key drives doInvRound key_in with the matching data_in -> output matches the reference model.
